// File: rtl/t03_alu_sched.sv
// t03_alu_sched: two-requester scheduler for the shared 32-bit ALU.
// Requester 0 is the core execute path and requester 1 is the auxiliary
// address/branch-compare engine. The winning operation is registered, driven
// to the ALU for one cycle, and its result and flags are returned on a
// per-requester valid/ready response channel.
// Build option: define T03_ALU_SCHED_RR_EN for round-robin arbitration.
// Without it, requester 0 has fixed priority when both requesters are valid.
module t03_alu_sched (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        owner_q;
  logic [31:0] result_q;
  logic [2:0]  flags_q;
  logic        grantIdx;
  logic        grantAny;
  logic        accept;

`ifdef T03_ALU_SCHED_RR_EN
  logic        lastGrant_q;

  // On a tie the grant goes to whichever requester did not win last time.
  always_comb begin
    grantAny = |req_valid;
    if (req_valid == 2'b11) begin
      grantIdx = ~lastGrant_q;
    end else begin
      grantIdx = req_valid[1];
    end
  end

  // Remember the most recent winner; starting at 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lastGrant_q <= 1'b1;
    end else if (accept) begin
      lastGrant_q <= grantIdx;
    end
  end
`else
  // Fixed priority: requester 1 is granted only when requester 0 is idle.
  always_comb begin
    grantAny = |req_valid;
    grantIdx = ~req_valid[0];
  end
`endif

  // Next-state and handshake decode; ready is only ever offered in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grantAny) begin
          req_ready[grantIdx] = 1'b1;
          accept              = 1'b1;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers load only on accept, so the ALU inputs hold steady otherwise.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      owner_q <= 1'b0;
    end else if (accept) begin
      owner_q <= grantIdx;
      if (grantIdx) begin
        op_q <= req1_op;
        a_q  <= req1_a;
        b_q  <= req1_b;
      end else begin
        op_q <= req0_op;
        a_q  <= req0_a;
        b_q  <= req0_b;
      end
    end
  end

  // Capture the ALU result and flags at the end of the single ISSUE cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      result_q <= 32'd0;
      flags_q  <= 3'd0;
    end else if (state_q == ISSUE) begin
      result_q <= alu_result;
      flags_q  <= {alu_overflow, alu_negative, alu_zero};
    end
  end

  // Response valid points at the owner only while a result is pending.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign rsp_result  = result_q;
  assign rsp_flags   = flags_q;
  assign alu_control = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_t03_alu_sched.sv
// tb_t03_alu_sched: scoreboard bench for t03_alu_sched with a behavioural ALU.
// The ALU model reports overflow as carry-out for ADD and borrow for SUB.
module tb_t03_alu_sched;

  logic        clk;
  logic        nrst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [3:0]  alu_control;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_negative;
  logic        alu_overflow;
  logic        busy;

  typedef struct {
    logic        owner;
    logic [31:0] result;
    logic [2:0]  flags;
  } expect_t;

  expect_t     expQ[$];
  int          numVectors;
  int          numMiscompares;
  logic        modelLast;
  logic [34:0] aluOut;
  logic [3:0]  opList [10] = '{4'b0000, 4'b1000, 4'b0100, 4'b0110, 4'b0111,
                               4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};

  t03_alu_sched dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .alu_control  (alu_control),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .busy         (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {overflow, negative, zero, result}.
  function automatic logic [34:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        ovf;
    wide = 33'd0;
    r    = 32'd0;
    ovf  = 1'b0;
    case (op)
      4'b0000: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[31:0];
        ovf  = wide[32];
      end
      4'b1000: begin
        r   = a - b;
        ovf = (a < b);
      end
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b0001: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b1101: r = 32'($signed(a) >>> b[4:0]);
      4'b0010: r = {31'd0, ($signed(a) < $signed(b))};
      4'b0011: r = {31'd0, (a < b)};
      default: r = 32'd0;
    endcase
    return {ovf, r[31], (r == 32'd0), r};
  endfunction

  // The ALU itself is combinational on the scheduler's drive.
  always_comb begin
    aluOut = aluRef(alu_control, alu_a, alu_b);
  end
  assign alu_result   = aluOut[31:0];
  assign alu_zero     = aluOut[32];
  assign alu_negative = aluOut[33];
  assign alu_overflow = aluOut[34];

  function automatic logic [1:0] oneHot(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  // Arbitration rule: a lone requester wins; on a tie, round-robin or requester 0.
  function automatic logic pickWinner(input logic [1:0] v, input logic last);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
`ifdef T03_ALU_SCHED_RR_EN
    return (last == 1'b0) ? 1'b1 : 1'b0;
`else
    return (last & 1'b0);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numVectors++;
    if (act !== exp) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One transaction, called just after a rising edge with the DUT in IDLE.
  task automatic applyStimulus(input logic [1:0] v,
                               input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input int hold);
    logic        g;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [34:0] r;
    logic [1:0]  rr;
    expect_t     e;
    req_valid = v;
    req0_op = op0; req0_a = a0; req0_b = b0;
    req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = 2'($urandom_range(0, 3));
    if (v == 2'b00) begin
      @(negedge clk);
      checkOutput("idle req_ready", 32'(req_ready), 32'd0);
      checkOutput("idle busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      return;
    end
    g  = pickWinner(v, modelLast);
    op = g ? op1 : op0;
    a  = g ? a1 : a0;
    b  = g ? b1 : b0;
    r  = aluRef(op, a, b);
    @(negedge clk);
    checkOutput("grant req_ready", 32'(req_ready), 32'(oneHot(g)));
    checkOutput("idle busy", 32'(busy), 32'd0);
    e.owner  = g;
    e.result = r[31:0];
    e.flags  = r[34:32];
    expQ.push_back(e);
    modelLast = g;
    @(posedge clk); #1;
    req_valid = 2'($urandom_range(0, 3));
    req0_a = $urandom; req1_a = $urandom;
    rsp_ready = 2'($urandom_range(0, 3));
    @(negedge clk);
    checkOutput("issue req_ready", 32'(req_ready), 32'd0);
    checkOutput("issue busy", 32'(busy), 32'd1);
    checkOutput("issue rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("alu_control", 32'(alu_control), 32'(op));
    checkOutput("alu_a", alu_a, a);
    checkOutput("alu_b", alu_b, b);
    @(posedge clk); #1;
    for (int k = 0; k <= hold; k++) begin
      rr = 2'($urandom_range(0, 3));
      rr[g] = (k == hold);
      rsp_ready = rr;
      @(negedge clk);
      checkOutput("resp req_ready", 32'(req_ready), 32'd0);
      checkOutput("resp busy", 32'(busy), 32'd1);
      checkOutput("resp alu_a stable", alu_a, a);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b00;
  endtask

  // Monitor: compare every presented response against the head of the scoreboard.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (nrst && rsp_valid != 2'b00) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          e = expQ[0];
          checkOutput("rsp_valid", 32'(rsp_valid), 32'(oneHot(e.owner)));
          checkOutput("rsp_result", rsp_result, e.result);
          checkOutput("rsp_flags", 32'(rsp_flags), 32'(e.flags));
          if (rsp_ready[e.owner]) begin
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [1:0]  v;
    logic [3:0]  o0;
    logic [3:0]  o1;
    numVectors = 0;
    numMiscompares = 0;
    modelLast = 1'b1;
    nrst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    #3;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset alu_a", alu_a, 32'd0);
    checkOutput("reset rsp_result", rsp_result, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    applyStimulus(2'b01, 4'b0000, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0, 0);
    applyStimulus(2'b10, 4'b0000, 32'd1, 32'd1, 4'b1000, 32'd3, 32'd3, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 4'b0110, $urandom, $urandom, 4'b0111, $urandom, $urandom, i);
    end
    applyStimulus(2'b01, 4'b0010, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 32'd0, 10);

    // Reset in the middle of ISSUE for an XOR from requester 0.
    req_valid = 2'b01;
    req0_op = 4'b0100; req0_a = 32'hA5A5_0F0F; req0_b = 32'h1234_5678;
    @(negedge clk);
    checkOutput("xor req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #2 nrst = 1'b0;
    #1;
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset req_ready", 32'(req_ready), 32'd0);
    checkOutput("midreset alu_control", 32'(alu_control), 32'd0);
    checkOutput("midreset alu_a", alu_a, 32'd0);
    checkOutput("midreset alu_b", alu_b, 32'd0);
    checkOutput("midreset rsp_result", rsp_result, 32'd0);
    checkOutput("midreset rsp_flags", 32'(rsp_flags), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    modelLast = 1'b1;
    applyStimulus(2'b10, 4'b0000, 32'd0, 32'd0, 4'b0001, 32'd3, 32'd4, 0);
    applyStimulus(2'b11, 4'b0000, 32'hFFFF_FFFF, 32'd1, 4'b0101, $urandom, $urandom, 2);

    for (int i = 0; i < 60; i++) begin
      v  = 2'($urandom_range(0, 3));
      o0 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : opList[$urandom_range(0, 9)];
      o1 = ($urandom_range(0, 7) == 0) ? 4'($urandom) : opList[$urandom_range(0, 9)];
      applyStimulus(v, o0, $urandom, 32'($urandom_range(0, 40)), o1, $urandom, $urandom,
                    int'($urandom_range(0, 3)));
    end

    @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
